// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: divides the system clock to a 10 ms tick and keeps
// elapsed time as four BCD digits SS.CC, cleared/held/advanced by the control state.
module stopwatch_timebase #(
  parameter int DIV   = 1_000_000,
  parameter int DIV_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       tick,
  output logic       wrap
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_COUNT = 2'd2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      digits_q, digits_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  // One-centisecond BCD increment; MSB of the result flags the 59.99 -> 00.00 rollover.
  function automatic logic [16:0] bcd_inc(input logic [15:0] d);
    logic [3:0] st, so, ct, co;
    logic       w;
    {st, so, ct, co} = d;
    w = 1'b0;
    if (co == 4'd9) begin
      co = 4'd0;
      if (ct == 4'd9) begin
        ct = 4'd0;
        if (so == 4'd9) begin
          so = 4'd0;
          if (st == 4'd5) begin
            st = 4'd0;
            w  = 1'b1;
          end else begin
            st = st + 4'd1;
          end
        end else begin
          so = so + 4'd1;
        end
      end else begin
        ct = ct + 4'd1;
      end
    end else begin
      co = co + 4'd1;
    end
    return {w, st, so, ct, co};
  endfunction

  // STOP and the reserved code fall through to the default: everything holds.
  always_comb begin
    div_d    = div_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        div_d    = '0;
        digits_d = '0;
      end
      ST_COUNT: begin
        if (div_q == DIV_LAST) begin
          div_d              = '0;
          {wrap_d, digits_d} = bcd_inc(digits_q);
          tick_d             = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign {sec_tens, sec_ones, cs_tens, cs_ones} = digits_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
- Consumer of the 2-bit stopwatch control state (IDLE=0, STOP=1, COUNTING=2) produced by the run/pause control FSM.
- Divides the system clock down to a 10 ms tick and keeps elapsed time as four BCD digits, SS.CC (00.00 to 59.99).
- Feeds the 7-segment display driver.
- Clears in IDLE, holds in STOP, advances in COUNTING.

Parameters:
- DIV, 1_000_000, clock cycles per 10 ms tick (100 MHz clock); must be >= 2. Benches use DIV=4.
- DIV_W, 20, width of the prescaler counter; must satisfy 2^DIV_W >= DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- state  input  2  control state: 0 IDLE, 1 STOP, 2 COUNTING, 3 reserved.
- sec_tens  output  4  BCD seconds tens digit, range 0..5.
- sec_ones  output  4  BCD seconds ones digit, range 0..9.
- cs_tens  output  4  BCD centiseconds tens digit, range 0..9.
- cs_ones  output  4  BCD centiseconds ones digit, range 0..9.
- tick  output  1  one-cycle pulse, high in the cycle the digits show a newly incremented value.
- wrap  output  1  one-cycle pulse, high together with tick when time rolls over 59.99 to 00.00.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler = 0, all four digits = 0, tick = 0, wrap = 0. No other state is held.
- All outputs are registered. No combinational path from state to any output.
- Prescaler div_cnt counts 0 to DIV-1, per state:
  - IDLE (0): div_cnt <= 0 and all digits <= 0 on the next edge. tick and wrap stay 0.
  - STOP (1): div_cnt and digits hold. tick and wrap are 0. The partial tick count is kept, so resuming finishes the interrupted 10 ms interval.
  - COUNTING (2): if div_cnt == DIV-1, then div_cnt <= 0, the digits increment by one centisecond and tick <= 1 on that same edge. Otherwise div_cnt <= div_cnt+1 and tick <= 0.
  - Reserved (3): behaves exactly as STOP.
- First tick timing: entering COUNTING from IDLE, the first tick appears DIV cycles after the first cycle with state==2 is sampled.
- BCD increment cascade, evaluated in one cycle:
  - cs_ones 9 -> 0 carries into cs_tens.
  - cs_tens 9 -> 0 carries into sec_ones.
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 on carry; this is the 59.99 -> 00.00 rollover, and wrap <= 1 with tick on that edge.
- Counting continues after rollover with no stall.
- State change takes effect on the edge that samples the new value:
  - COUNTING -> STOP in the same cycle div_cnt == DIV-1 produces no tick; div_cnt stays at DIV-1, and the tick fires on the first COUNTING cycle after resume.
  - STOP -> IDLE clears on the next edge.
  - IDLE -> COUNTING starts from 00.00 with div_cnt = 0.
- Reset mid-count: the digits drop to 00.00 immediately (asynchronously); no tick or wrap is emitted during or after release.
- Digits never leave legal BCD ranges (sec_tens <= 5, others <= 9). The bench asserts this every cycle.

Test Plan:
- Reset then idle: rst_n low 3 cycles, state=0 for 20 cycles -> digits 00.00, tick and wrap never asserted.
- Basic count (DIV=4): state=2 for 40 cycles from reset -> tick exactly every 4th cycle, 10 ticks, digits 00.10 at end.
- Pause/resume mid-interval (DIV=4): COUNTING 6 cycles (1 tick, div_cnt=2), STOP 10 cycles, then COUNTING again -> digits hold 00.01 during STOP, next tick 2 cycles after resume, digits 00.02.
- Pause on the tick boundary: drop to STOP in the cycle div_cnt==3 -> no tick that cycle, digits unchanged; after return to COUNTING the tick fires on the first COUNTING edge.
- Cascade and rollover (DIV=4): run 5999 ticks -> digits 59.99, wrap 0. One more tick -> 00.00 with tick=1 and wrap=1 in the same cycle. Also check 00.99 -> 01.00 and 09.99 -> 10.00 on the way.
- Clear and async reset: at 12.34, state=0 -> 00.00 on the next edge. At 05.67, pulse rst_n low between clock edges -> digits 00.00 before the next rising edge, and counting resumes cleanly with state=2.
